// File: rtl/ebpc_pkg.sv
// Shared types and defaults for the EBPC encoder front end.
// Holds the input-splitter state encoding, default widths and a small
// saturating-increment helper used by the optional statistics counters.
package ebpc_pkg;

    // Activation word width used when the instantiating level does not override it.
    localparam int DEFAULT_DATA_W     = 8;
    // Words per block; must be a power of two and at least 2.
    localparam int DEFAULT_BLOCK_SIZE = 8;

    // Input splitter control states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        FLUSH     = 2'd2,
        WAIT_DONE = 2'd3
    } split_state_t;

    // 32-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ebpc_out_reg.sv
// One-entry registered valid/ready slice.
// A load writes the entry; an accepted beat (vld & rdy) empties it. A load
// in the same cycle as a drain replaces the entry, so a stream can pass at
// one beat per cycle. free_o tells the producer whether a load is allowed.
module ebpc_out_reg #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         free_o,
    output logic         vld_o,
    output logic [W-1:0] data_o,
    input  logic         rdy_i
);

    logic         r_vld;
    logic [W-1:0] r_data;

    // Empty, or the current beat leaves at this clock edge.
    assign free_o = ~r_vld | rdy_i;
    assign vld_o  = r_vld;
    assign data_o = r_data;

    // Entry register: load wins over drain, drain clears valid.
    always_ff @(posedge clk_i) begin
        // NOTE: the data field is reset as well as valid, because every output must read 0 during reset.
        if (rst_i) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (load_i) begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            r_vld  <= 1'b1;
            r_data <= data_i;
        end else if (rdy_i) begin
            r_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/ebpc_input_splitter.sv
// EBPC input splitter: cuts the activation stream into blocks of BLOCK_SIZE
// words, sends a nonzero flag per word to the ZNZ encoder and the nonzero
// words to the BPC encoder, each with its per-block last flag.
// The most recent nonzero word is parked in a hold register until the next
// nonzero word or the block end reveals whether it is the last BPC beat.
// After a block the splitter stalls until the done tracker answers.
// Optional build macro: EBPC_SPLIT_PERF_CNT_EN adds saturating block and
// zero-word counters (blk_cnt_o, zero_word_cnt_o).
module ebpc_input_splitter
    import ebpc_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic              znz_data_o,
    output logic              znz_last_o,
    output logic              znz_vld_o,
    input  logic              znz_rdy_i,
    output logic [DATA_W-1:0] bpc_data_o,
    output logic              bpc_last_o,
    output logic              bpc_vld_o,
    input  logic              bpc_rdy_i,
    output logic              blk_start_o,
    input  logic              blk_done_i
`ifdef EBPC_SPLIT_PERF_CNT_EN
    ,
    output logic [31:0]       blk_cnt_o,
    output logic [31:0]       zero_word_cnt_o
`endif
);

    localparam int CNT_W = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_SIZE - 1);

    split_state_t      r_state;
    split_state_t      w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_hold_vld;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_blk_start;

    logic              w_znz_free;
    logic              w_bpc_free;
    logic              w_rdy;
    logic              w_accept;
    logic              w_nz;
    logic              w_block_end;
    logic              w_bpc_load;
    logic [DATA_W:0]   w_bpc_din;

    // Words are taken only while a block is open and both encoders can absorb a beat.
    assign w_rdy = ~rst_i
                 & ((r_state == IDLE) | (r_state == ACTIVE))
                 & w_znz_free & w_bpc_free;
    assign rdy_o       = w_rdy;
    assign w_accept    = vld_i & w_rdy;
    assign w_nz        = (data_i != '0);
    assign w_block_end = (r_cnt == CNT_MAX) | last_i;
    assign blk_start_o = r_blk_start;

    // ZNZ slice: one {nonzero, last} beat per accepted word.
    ebpc_out_reg #(
        .W (2)
    ) u_znz_reg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_accept),
        .data_i ({w_nz, w_block_end}),
        .free_o (w_znz_free),
        .vld_o  (znz_vld_o),
        .data_o ({znz_data_o, znz_last_o}),
        .rdy_i  (znz_rdy_i)
    );

    // BPC slice: nonzero words with their block-last flag.
    ebpc_out_reg #(
        .W (DATA_W + 1)
    ) u_bpc_reg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_bpc_load),
        .data_i (w_bpc_din),
        .free_o (w_bpc_free),
        .vld_o  (bpc_vld_o),
        .data_o ({bpc_data_o, bpc_last_o}),
        .rdy_i  (bpc_rdy_i)
    );

    // Next state and BPC slice load control.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next_state = r_state;
        w_bpc_load   = 1'b0;
        w_bpc_din    = {r_hold_data, 1'b0};
        case (r_state)
            IDLE, ACTIVE: begin
                if (w_accept) begin
                    // A new nonzero word proves the held word was not the last one.
                    if (w_nz && r_hold_vld) begin
                        w_bpc_load = 1'b1;
                    end
                    if (w_block_end) begin
                        w_next_state = (r_hold_vld || w_nz) ? FLUSH : WAIT_DONE;
                    end else begin
                        w_next_state = ACTIVE;
                    end
                end
            end
            FLUSH: begin
                if (w_bpc_free) begin
                    w_bpc_load   = 1'b1;
                    w_bpc_din    = {r_hold_data, 1'b1};
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (blk_done_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word position inside the current block; restarts after every block end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_block_end ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Hold register: latest nonzero word, emptied when FLUSH hands it to the BPC slice.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (w_accept && w_nz) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= data_i;
        end else if (r_state == FLUSH && w_bpc_free) begin
            r_hold_vld  <= 1'b0;
        end
    end

    // Block-start pulse, one cycle after the first word of a block is taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_blk_start <= 1'b0;
        end else begin
            r_blk_start <= w_accept && (r_state == IDLE);
        end
    end

`ifdef EBPC_SPLIT_PERF_CNT_EN
    logic [31:0] r_blk_cnt;
    logic [31:0] r_zero_word_cnt;

    assign blk_cnt_o       = r_blk_cnt;
    assign zero_word_cnt_o = r_zero_word_cnt;

    // Completed blocks (entry into WAIT_DONE) and accepted zero words, both saturating.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_blk_cnt       <= '0;
            r_zero_word_cnt <= '0;
        end else begin
            if (w_next_state == WAIT_DONE && r_state != WAIT_DONE) begin
                r_blk_cnt <= sat_inc32(r_blk_cnt);
            end
            if (w_accept && !w_nz) begin
                r_zero_word_cnt <= sat_inc32(r_zero_word_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ebpc_input_splitter.sv
// Scoreboard bench for ebpc_input_splitter: directed blocks push hand-computed
// ZNZ/BPC beats into queues, a negedge monitor pops and compares every beat
// and checks that stalled beats stay stable. The bench plays the done tracker.
module tb_ebpc_input_splitter;

    localparam int DW = 8;

    typedef logic [DW-1:0] warr_t [8];

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] data_i;
    logic          last_i;
    logic          vld_i;
    logic          rdy_o;
    logic          znz_data_o;
    logic          znz_last_o;
    logic          znz_vld_o;
    logic          znz_rdy_i;
    logic [DW-1:0] bpc_data_o;
    logic          bpc_last_o;
    logic          bpc_vld_o;
    logic          bpc_rdy_i;
    logic          blk_start_o;
    logic          blk_done_i;
`ifdef EBPC_SPLIT_PERF_CNT_EN
    logic [31:0]   blk_cnt_o;
    logic [31:0]   zero_word_cnt_o;
`endif

    logic [1:0]    znz_q [$];
    logic [DW:0]   bpc_q [$];
    int            total = 0;
    int            bad = 0;
    int            starts_seen = 0;
    int            starts_exp = 0;
    bit            bp_en = 1'b0;
    warr_t         wa;
    warr_t         ba;

    always #5 clk_i = ~clk_i;

    ebpc_input_splitter #(
        .DATA_W     (DW),
        .BLOCK_SIZE (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .data_i          (data_i),
        .last_i          (last_i),
        .vld_i           (vld_i),
        .rdy_o           (rdy_o),
        .znz_data_o      (znz_data_o),
        .znz_last_o      (znz_last_o),
        .znz_vld_o       (znz_vld_o),
        .znz_rdy_i       (znz_rdy_i),
        .bpc_data_o      (bpc_data_o),
        .bpc_last_o      (bpc_last_o),
        .bpc_vld_o       (bpc_vld_o),
        .bpc_rdy_i       (bpc_rdy_i),
        .blk_start_o     (blk_start_o),
        .blk_done_i      (blk_done_i)
`ifdef EBPC_SPLIT_PERF_CNT_EN
        ,
        .blk_cnt_o       (blk_cnt_o),
        .zero_word_cnt_o (zero_word_cnt_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer readies: always high, or a coin flip per cycle under backpressure.
    always @(posedge clk_i) begin
        #1;
        znz_rdy_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bpc_rdy_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compare each transferred beat with the scoreboard, check stall stability.
    logic [1:0]  znz_prev;
    logic [DW:0] bpc_prev;
    bit          znz_stalled = 1'b0;
    bit          bpc_stalled = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            znz_stalled = 1'b0;
            bpc_stalled = 1'b0;
        end else begin
            if (znz_stalled) begin
                check("znz_stall_vld", 32'(znz_vld_o), 32'd1);
                check("znz_stall_data", 32'({znz_data_o, znz_last_o}), 32'(znz_prev));
            end
            if (bpc_stalled) begin
                check("bpc_stall_vld", 32'(bpc_vld_o), 32'd1);
                check("bpc_stall_data", 32'({bpc_data_o, bpc_last_o}), 32'(bpc_prev));
            end
            if (znz_vld_o && znz_rdy_i) begin
                if (znz_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL znz_extra: got beat %b expected none", {znz_data_o, znz_last_o});
                end else begin
                    check("znz_beat", 32'({znz_data_o, znz_last_o}), 32'(znz_q.pop_front()));
                end
            end
            if (bpc_vld_o && bpc_rdy_i) begin
                if (bpc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bpc_extra: got beat %h/%b expected none", bpc_data_o, bpc_last_o);
                end else begin
                    check("bpc_beat", 32'({bpc_data_o, bpc_last_o}), 32'(bpc_q.pop_front()));
                end
            end
            znz_stalled = znz_vld_o & ~znz_rdy_i;
            znz_prev    = {znz_data_o, znz_last_o};
            bpc_stalled = bpc_vld_o & ~bpc_rdy_i;
            bpc_prev    = {bpc_data_o, bpc_last_o};
            if (blk_start_o) starts_seen++;
        end
    end

    // Offer one word from posedge+1 until it is taken; returns at posedge+1.
    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int n = 0;
        bit ok = 1'b0;
        data_i = d;
        last_i = l;
        vld_i  = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk_i);
            ok = rdy_o;
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %h not accepted within %0d cycles", d, n);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Wait for all expected beats, check the WAIT_DONE stall, then answer with a done pulse.
    task automatic finish_block();
        int n = 0;
        while ((znz_q.size() != 0 || bpc_q.size() != 0) && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: znz left %0d bpc left %0d expected 0", znz_q.size(), bpc_q.size());
        end
        repeat (2) begin
            @(negedge clk_i);
            check("wait_done_rdy", 32'(rdy_o), 32'd0);
        end
        @(posedge clk_i);
        #1 blk_done_i = 1'b1;
        @(posedge clk_i);
        #1 blk_done_i = 1'b0;
        @(negedge clk_i);
        check("after_done_rdy", 32'(rdy_o), 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    // Issue a block and push its hand-computed ZNZ ({nz,last} per word) and BPC beats.
    task automatic send_block(input int n, input bit end_last, input logic [7:0] nz_mask,
                              input logic [7:0] last_mask, input int nb);
        for (int i = 0; i < n; i++) znz_q.push_back({nz_mask[i], last_mask[i]});
        for (int j = 0; j < nb; j++) bpc_q.push_back({ba[j], 1'(j == nb - 1)});
        starts_exp++;
        for (int i = 0; i < n; i++) send_word(wa[i], end_last && (i == n - 1));
        vld_i  = 1'b0;
        last_i = 1'b0;
        finish_block();
    endtask

    task automatic blk_sparse();
        wa = '{8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00};
        ba = '{8'h03, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_block(8, 1'b0, 8'h45, 8'h80, 3);
    endtask

    task automatic blk_zero();
        wa = '{default: 8'h00};
        ba = '{default: 8'h00};
        send_block(8, 1'b0, 8'h00, 8'h80, 0);
    endtask

    task automatic blk_dense();
        wa = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        ba = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_block(8, 1'b0, 8'hFF, 8'h80, 8);
    endtask

    task automatic blk_short();
        wa = '{8'h09, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ba = '{8'h09, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_block(3, 1'b1, 8'h05, 8'h04, 2);
    endtask

    task automatic blk_single();
        wa = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ba = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_block(1, 1'b1, 8'h01, 8'h01, 1);
    endtask

    task automatic blk_mixed();
        wa = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h44};
        ba = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        send_block(8, 1'b0, 8'h8D, 8'h80, 4);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdy"}, 32'(rdy_o), 32'd0);
        check({tag, "_znz_vld"}, 32'(znz_vld_o), 32'd0);
        check({tag, "_znz_data"}, 32'({znz_data_o, znz_last_o}), 32'd0);
        check({tag, "_bpc_vld"}, 32'(bpc_vld_o), 32'd0);
        check({tag, "_bpc_data"}, 32'({bpc_data_o, bpc_last_o}), 32'd0);
        check({tag, "_blk_start"}, 32'(blk_start_o), 32'd0);
`ifdef EBPC_SPLIT_PERF_CNT_EN
        check({tag, "_blk_cnt"}, blk_cnt_o, 32'd0);
        check({tag, "_zero_cnt"}, zero_word_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        rst_i      = 1'b1;
        data_i     = '0;
        last_i     = 1'b0;
        vld_i      = 1'b0;
        blk_done_i = 1'b0;
        znz_rdy_i  = 1'b1;
        bpc_rdy_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_outputs_zero("reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Directed blocks with both consumers always ready.
        blk_sparse();
        blk_zero();
        blk_dense();
        blk_short();
        blk_sparse();
        blk_single();

        // Same traffic under random backpressure on both consumers.
        bp_en = 1'b1;
        blk_mixed();
        blk_sparse();
        blk_dense();
        blk_short();
        blk_single();
        blk_zero();
        bp_en = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset in the middle of a block: beats already out are checked, the rest discarded.
        znz_q.push_back(2'b10);
        znz_q.push_back(2'b00);
        znz_q.push_back(2'b10);
        znz_q.push_back(2'b00);
        bpc_q.push_back({8'h03, 1'b0});
        starts_exp++;
        send_word(8'h03, 1'b0);
        send_word(8'h00, 1'b0);
        send_word(8'h05, 1'b0);
        send_word(8'h00, 1'b0);
        vld_i = 1'b0;
        rst_i = 1'b1;
        znz_q.delete();
        bpc_q.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs_zero("mid_reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // A fresh block after reset behaves like the first one.
        blk_sparse();

        check("znz_left", 32'(znz_q.size()), 32'd0);
        check("bpc_left", 32'(bpc_q.size()), 32'd0);
        check("blk_start_pulses", 32'(starts_seen), 32'(starts_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ebpc_input_splitter.md
Name: ebpc_input_splitter

Overview:
- Upstream stage of the EBPC encoder.
- Takes the raw activation word stream and cuts it into blocks of BLOCK_SIZE words.
- Sends one nonzero flag per word to the ZNZ encoder and only the nonzero words to the BPC encoder, with correct per-block last flags on both.
- Produces the block-start pulse for the block-done tracker and holds off the next block until block-done returns.

Parameters:
- DATA_W, 8, activation word width.
- BLOCK_SIZE, 8, words per block; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- data_i  in  DATA_W  input word.
- last_i  in  1  final word of tensor; closes the current block early.
- vld_i  in  1  input valid.
- rdy_o  out  1  input ready.
- znz_data_o  out  1  1 = word nonzero.
- znz_last_o  out  1  last flag of block.
- znz_vld_o  out  1  ZNZ valid.
- znz_rdy_i  in  1  ZNZ ready.
- bpc_data_o  out  DATA_W  nonzero word.
- bpc_last_o  out  1  last nonzero word of block.
- bpc_vld_o  out  1  BPC valid.
- bpc_rdy_i  in  1  BPC ready.
- blk_start_o  out  1  one-cycle pulse on acceptance of the first word of a block.
- blk_done_i  in  1  one-cycle pulse from the done tracker.

Behaviour:
- Reset is synchronous, active-high, on clk_i. While rst_i is high, every output is 0 and the FSM is IDLE; all registers and counters clear. Reset mid-block discards in-flight data; no done pulse is expected afterwards.
- Handshakes: valid/ready. A transfer occurs on a cycle with vld & rdy. Outputs are registered; once valid is high, valid and data stay stable until ready. Output registers may reload in the same cycle they drain.
- Registers:
  - ZNZ out-reg.
  - BPC out-reg.
  - BPC hold-reg: one entry, the most recent nonzero word, because bpc_last is unknown until block end.
  - Word counter: $clog2(BLOCK_SIZE) bits.
- Block end: a word is the block end word when cnt==BLOCK_SIZE-1 or last_i=1. cnt resets to 0 at block end.
- FSM state IDLE:
  - rdy_o follows ACTIVE rules.
  - The first accepted word raises blk_start_o for one cycle (the cycle after acceptance) and the FSM moves to ACTIVE.
- FSM state ACTIVE:
  - rdy_o = ZNZ out-reg free-or-draining AND BPC out-reg free-or-draining.
  - Per accepted word: ZNZ out-reg loads (data!=0, block end).
  - If the word is nonzero and the hold-reg is valid: hold-reg goes to the BPC out-reg with last=0; the word goes to the hold-reg.
  - If the word is nonzero and the hold-reg is empty: the word goes to the hold-reg.
  - At block end:
    - If the hold-reg ends up valid, the FSM goes to FLUSH.
    - Else (all-zero block) the FSM goes to WAIT_DONE and no BPC beat is emitted.
- FSM state FLUSH:
  - rdy_o=0.
  - When the BPC out-reg is free or draining: hold-reg goes to the BPC out-reg with last=1, the hold-reg clears, and the FSM goes to WAIT_DONE.
- FSM state WAIT_DONE:
  - rdy_o=0.
  - blk_done_i goes to IDLE. blk_done_i in any other state is ignored.
- Simultaneous events:
  - When a nonzero block-end word is accepted while the hold-reg is valid, the old hold word is emitted last=0 in that cycle and the new word is emitted last=1 via FLUSH.
  - A blk_done_i pulse coinciding with the FLUSH transfer is ignored; the tracker cannot finish before the BPC last beat, so this case does not occur legally.
- last_i with cnt=0 forms a one-word block.
- Throughput: one word per cycle within a block. Inter-block overhead is ≥2 cycles (FLUSH + done round trip).

Optional Feature:
- Macro: EBPC_SPLIT_PERF_CNT_EN.
- When defined:
  - Adds outputs blk_cnt_o (32-bit) and zero_word_cnt_o (32-bit).
  - blk_cnt_o counts blocks completed (increments on the transition to WAIT_DONE).
  - zero_word_cnt_o counts accepted zero words.
  - Both saturate at all-ones and clear on rst_i.
- When undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package ebpc_pkg: split_state_t enum {IDLE, ACTIVE, FLUSH, WAIT_DONE}, default DATA_W and BLOCK_SIZE constants.
- One sub-module, ebpc_out_reg: a one-entry registered valid/ready slice with load/drain. Instantiated twice (ZNZ width 2, BPC width DATA_W+1).

Test Plan:
- Block 3,0,5,0,0,0,7,0 with both readies high → ZNZ flags 1,0,1,0,0,0,1,0 with last on the 8th; BPC beats 3(l0),5(l0),7(l1); blk_start_o one pulse.
- Eight zero words → ZNZ eight 0 flags, last on the 8th; no BPC beat; WAIT_DONE until blk_done_i, then the next word is accepted.
- Block ending in nonzero after a nonzero (1..8 all nonzero) → BPC 1..7 last=0, then 8 last=1 one cycle later via FLUSH.
- last_i on the 3rd word (9,0,4) → ZNZ last on the 3rd; BPC 9(l0),4(l1); cnt restarts at 0 for the next block.
- Random bpc_rdy_i/znz_rdy_i backpressure at 50% → no beat lost or duplicated; valid/data stable while stalled; per-block order preserved.
- rst_i asserted in ACTIVE after 4 words → next cycle all outputs 0, FSM IDLE; a fresh block behaves as in scenario 1. With EBPC_SPLIT_PERF_CNT_EN, counters read 0.
